// File: rtl/arm_pkg.sv
// Shared types and defaults for the writeback stage.
// Holds the WB pipeline register layout.
package arm_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int NREGS_DEF = 32;
  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic [4:0]           rd;
    logic [WIDTH_DEF-1:0] data;
    logic                 written;
  } wb_reg_t;
endpackage

// File: rtl/wb_decoder.sv
// Register index to one-hot write-enable decoder.
// Output is all-zero when en is low.
module wb_decoder #(
  parameter int N = 32
) (
  input  logic [4:0]   idx,
  input  logic         en,
  output logic [N-1:0] onehot
);
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = en && (idx == 5'(i));
    end
  end
endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: WB register, bank write enables,
// forwarding tap and saturating commit counter.
module writeback_stage
  import arm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_valid,
  input  logic                        mem_regwrite,
  input  logic                        mem_memtoreg,
  input  logic [4:0]                  mem_rd,
  input  logic [WIDTH-1:0]            mem_alu_result,
  input  logic [WIDTH-1:0]            mem_load_data,
  input  logic                        wb_stall,
  input  logic                        wb_flush,
  output logic [NREGS-1:0][WIDTH-1:0] rf_in,
  output logic [NREGS-1:0]            rf_enables,
  output logic                        fwd_valid,
  output logic [4:0]                  fwd_rd,
  output logic [WIDTH-1:0]            fwd_data,
  output logic [15:0]                 commit_count
);
  localparam logic [4:0] XZR = 5'(NREGS - 1);

  wb_reg_t          s;
  logic             we;
  logic             to_xzr;
  logic [WIDTH-1:0] cap;

  assign cap    = mem_memtoreg ? mem_load_data : mem_alu_result;
  assign to_xzr = (s.rd == XZR);
  assign we     = s.valid & s.regwrite & ~to_xzr & ~s.written;

  // written marks a stalled instruction whose single write already issued
  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
    end else if (wb_flush) begin
      s <= '0;
    end else if (wb_stall) begin
      s.written <= s.written | we;
    end else begin
      s.valid    <= mem_valid;
      s.regwrite <= mem_regwrite;
      s.rd       <= mem_rd;
      s.data     <= WIDTH_DEF'(cap);
      s.written  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_count <= '0;
    end else if (we && commit_count != 16'hFFFF) begin
      commit_count <= commit_count + 16'd1;
    end
  end

  wb_decoder #(.N(NREGS)) u_dec (
    .idx    (s.rd),
    .en     (we),
    .onehot (rf_enables)
  );

  assign fwd_valid = s.valid & s.regwrite & ~to_xzr;
  assign fwd_rd    = s.rd;
  assign fwd_data  = WIDTH'(s.data);

  for (genvar i = 0; i < NREGS; i++) begin : g_rf
    assign rf_in[i] = fwd_data;
  end
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed
// vectors push expectations, a monitor pops and compares.
module tb_writeback_stage;
  localparam int W = 64;
  localparam int N = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_valid;
  logic              mem_regwrite;
  logic              mem_memtoreg;
  logic [4:0]        mem_rd;
  logic [W-1:0]      mem_alu_result;
  logic [W-1:0]      mem_load_data;
  logic              wb_stall;
  logic              wb_flush;
  logic [N-1:0][W-1:0] rf_in;
  logic [N-1:0]      rf_enables;
  logic              fwd_valid;
  logic [4:0]        fwd_rd;
  logic [W-1:0]      fwd_data;
  logic [15:0]       commit_count;

  writeback_stage #(.WIDTH(W), .NREGS(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_regwrite   (mem_regwrite),
    .mem_memtoreg   (mem_memtoreg),
    .mem_rd         (mem_rd),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .wb_stall       (wb_stall),
    .wb_flush       (wb_flush),
    .rf_in          (rf_in),
    .rf_enables     (rf_enables),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data),
    .commit_count   (commit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [N-1:0] en;
    logic         fv;
    logic [4:0]   rd;
    logic [W-1:0] d;
    logic [15:0]  cnt;
    logic         cf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  task automatic cmp(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    logic all_eq;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp({e.name, ".en"}, W'(rf_enables), W'(e.en));
        cmp({e.name, ".fv"}, W'(fwd_valid), W'(e.fv));
        cmp({e.name, ".cnt"}, W'(commit_count), W'(e.cnt));
        if (e.cf) begin
          cmp({e.name, ".rd"}, W'(fwd_rd), W'(e.rd));
          cmp({e.name, ".data"}, fwd_data, e.d);
          all_eq = 1'b1;
          for (int i = 0; i < N; i++)
            if (rf_in[i] !== e.d) all_eq = 1'b0;
          cmp({e.name, ".rf_in"}, W'(all_eq), W'(1'b1));
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic mv,
                       input logic rw, input logic mtr,
                       input logic [4:0] rd,
                       input logic [W-1:0] alu,
                       input logic [W-1:0] ld,
                       input logic st, input logic fl);
    reset          = rst;
    mem_valid      = mv;
    mem_regwrite   = rw;
    mem_memtoreg   = mtr;
    mem_rd         = rd;
    mem_alu_result = alu;
    mem_load_data  = ld;
    wb_stall       = st;
    wb_flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_(input string nm, input logic [N-1:0] en,
                         input logic fv, input logic [4:0] rd,
                         input logic [W-1:0] d, input logic [15:0] cnt,
                         input logic cf);
    exp_t e;
    e.name = nm; e.en = en; e.fv = fv; e.rd = rd;
    e.d = d; e.cnt = cnt; e.cf = cf;
    q.push_back(e);
  endtask

  initial begin
    int guard;
    #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_("rst0", 0, 0, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 5, 64'h9, 0, 0, 0);
    expect_("rst1", 0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 5, 64'h1234, 64'h1, 0, 0);
    expect_("cap5", 32'h20, 1, 5, 64'h1234, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_("bub1", 0, 0, 0, 0, 1, 1);
    drive(0, 1, 1, 0, 31, 64'h55, 0, 0, 0);
    expect_("xzr", 0, 0, 31, 64'h55, 1, 1);
    drive(0, 1, 1, 1, 3, 64'h99, 64'hDEAD, 0, 0);
    expect_("ld3", 32'h8, 1, 3, 64'hDEAD, 1, 1);
    drive(0, 1, 1, 0, 9, 64'h77, 0, 1, 0);
    expect_("stl1", 0, 1, 3, 64'hDEAD, 2, 1);
    drive(0, 1, 1, 0, 9, 64'h77, 0, 1, 0);
    expect_("stl2", 0, 1, 3, 64'hDEAD, 2, 1);
    drive(0, 1, 1, 0, 9, 64'h77, 0, 1, 0);
    expect_("stl3", 0, 1, 3, 64'hDEAD, 2, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_("bub2", 0, 0, 0, 0, 2, 1);
    drive(0, 1, 1, 0, 10, 64'hABC, 0, 0, 0);
    expect_("cap10", 32'h400, 1, 10, 64'hABC, 2, 1);
    drive(0, 1, 1, 0, 4, 64'h11, 0, 1, 1);
    expect_("flst", 0, 0, 0, 0, 3, 0);
    drive(0, 1, 0, 0, 6, 64'h66, 0, 0, 0);
    expect_("norw", 0, 0, 6, 64'h66, 3, 1);
    // back-to-back writes bring the count to 16'hFFFC
    for (int i = 0; i < 65530; i++)
      drive(0, 1, 1, 0, 1, W'(i), 0, 0, 0);
    drive(0, 1, 1, 0, 2, 64'h2, 0, 0, 0);
    expect_("satA", 32'h4, 1, 2, 64'h2, 16'hFFFD, 1);
    drive(0, 1, 1, 0, 2, 64'h3, 0, 0, 0);
    expect_("satB", 32'h4, 1, 2, 64'h3, 16'hFFFE, 1);
    drive(0, 1, 1, 0, 2, 64'h4, 0, 0, 0);
    expect_("satC", 32'h4, 1, 2, 64'h4, 16'hFFFF, 1);
    drive(0, 1, 1, 0, 2, 64'h5, 0, 0, 0);
    expect_("satD", 32'h4, 1, 2, 64'h5, 16'hFFFF, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_("satE", 0, 0, 0, 0, 16'hFFFF, 1);
    drive(0, 1, 1, 0, 7, 64'h70, 0, 0, 0);
    expect_("cap7", 32'h80, 1, 7, 64'h70, 16'hFFFF, 1);
    drive(1, 1, 1, 0, 7, 64'h70, 0, 1, 0);
    expect_("rstst", 0, 0, 0, 0, 0, 1);
    drive(0, 1, 1, 0, 7, 64'h70, 0, 1, 0);
    expect_("post1", 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_("post2", 0, 0, 0, 0, 0, 1);
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter WIDTH, default 64, register data width in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers; index NREGS-1 is XZR.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port mem_valid  input  1  the MEM stage holds a real instruction (0 = bubble).
REQ-006 Port mem_regwrite  input  1  the instruction writes a destination register.
REQ-007 Port mem_memtoreg  input  1  1 selects mem_load_data, 0 selects mem_alu_result.
REQ-008 Port mem_rd  input  5  destination register index.
REQ-009 Port mem_alu_result  input  WIDTH  ALU result.
REQ-010 Port mem_load_data  input  WIDTH  data-memory read data.
REQ-011 Port wb_stall  input  1  hold the WB register contents.
REQ-012 Port wb_flush  input  1  replace the WB contents with a bubble.
REQ-013 Port rf_in  output  [NREGS-1:0][WIDTH-1:0]  write data for the register bank; every entry equals wb_data.
REQ-014 Port rf_enables  output  NREGS  one-hot, or all-zero, write enables for the register bank.
REQ-015 Port fwd_valid  output  1  the WB stage holds a forwardable result.
REQ-016 Port fwd_rd  output  5  register index of the forwardable result.
REQ-017 Port fwd_data  output  WIDTH  value of the forwardable result.
REQ-018 Port commit_count  output  16  saturating count of register writes issued.

Function
REQ-019 The WB register (valid, regwrite, rd, data, written) SHALL load at each edge with priority reset > wb_flush > wb_stall > normal capture.
REQ-020 Normal capture SHALL set valid=mem_valid, regwrite=mem_regwrite, rd=mem_rd, written=0, and data=(mem_memtoreg ? mem_load_data : mem_alu_result).
REQ-021 wb_flush SHALL load a bubble (valid=0, written=0) even when wb_stall is also asserted.
REQ-022 wb_stall without flush SHALL hold valid, regwrite, rd and data; written SHALL become 1 if a write issued this cycle, otherwise it holds.
REQ-023 Define we = valid & regwrite & (rd != NREGS-1) & !written.
REQ-024 rf_enables SHALL be combinational from WB state: bit rd = we, all other bits 0; it SHALL be all-zero for rd=31 (XZR).
REQ-025 Latency SHALL be one edge into WB; the bank writes on the following edge, so a value captured at edge N is readable from the bank after edge N+1.
REQ-026 A stalled instruction SHALL assert its enable for exactly one cycle, i.e. a single write per instruction.
REQ-027 fwd_valid SHALL be valid & regwrite & (rd != NREGS-1), independent of written; fwd_rd=rd; fwd_data=data.
REQ-028 commit_count SHALL increment by 1 on each edge where we=1 and SHALL saturate at 16'hFFFF without wrapping.
REQ-029 Invalid (valid=0) or non-writing instructions SHALL produce all-zero rf_enables and SHALL NOT be counted.

Reset
REQ-030 When reset=1 at an edge, the stage SHALL set valid=0, regwrite=0, rd=0, data=0, written=0 and commit_count=0; rf_enables=0 and fwd_valid=0 from the next cycle.
REQ-031 Reset asserted mid-stall SHALL discard the held instruction with no write.

Structure
REQ-032 Package arm_pkg SHALL hold WIDTH_DEF=64, NREGS_DEF=32, XZR_IDX=5'd31 and a wb_reg_t struct {valid, regwrite, rd, data, written}.
REQ-033 The 5-to-32 one-hot enable decoder SHALL be one sub-module, wb_decoder (inputs idx and en, output onehot).

Verification
REQ-034 Capture rd=5, ALU=0x1234, memtoreg=0, regwrite=1 -> next cycle rf_enables=32'h20, rf_in[*]=0x1234, commit_count=1.
REQ-035 Capture rd=31, regwrite=1 -> rf_enables=0, fwd_valid=0, commit_count unchanged.
REQ-036 Capture rd=3 with load_data=0xDEAD and memtoreg=1, then wb_stall for 3 cycles -> rf_enables=32'h8 only in the first cycle, fwd_valid=1 for all 4 cycles, commit_count +1.
REQ-037 wb_flush and wb_stall asserted together with a valid write held -> next cycle rf_enables=0 and fwd_valid=0.
REQ-038 Preload commit_count to 16'hFFFE via 2 further writes -> the count reads 16'hFFFF and stays there.
REQ-039 reset asserted while stalled on rd=7 -> no enable after reset and commit_count=0.
